// File: rtl/monkey_pkg.sv
// Shared definitions for the monkey collision path: edge bit positions,
// state encoding and sprite geometry shared with the movement block.
package monkey_pkg;

  localparam int EDGE_LEFT   = 3;
  localparam int EDGE_TOP    = 2;
  localparam int EDGE_RIGHT  = 1;
  localparam int EDGE_BOTTOM = 0;

  localparam int OBJECT_WIDTH_DEF  = 64;
  localparam int OBJECT_HEIGHT_DEF = 64;
  localparam int EDGE_W_DEF        = 8;
  localparam int EDGE_H_DEF        = 8;
  localparam int HIT_THRESHOLD_DEF = 2;

  localparam int COORD_W = 11;
  localparam int OFF_W   = 12;
  localparam int CNT_W   = 8;

  typedef logic [3:0] edge_code_t;

  typedef enum logic {
    ACCUM  = 1'b0,
    REPORT = 1'b1
  } fsm_t;

endpackage

// File: rtl/monkey_collision_detector_sat_hit_counter.sv
// 8-bit saturating hit counter with synchronous clear and a threshold flag.
module sat_hit_counter
  import monkey_pkg::*;
#(
  parameter int THRESHOLD = HIT_THRESHOLD_DEF
) (
  input  logic clk,
  input  logic resetN,
  input  logic clr_i,
  input  logic inc_i,
  output logic hit_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear has priority; increments stop at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_o = (int'(cnt_q) >= THRESHOLD);

endmodule

// File: rtl/monkey_collision_detector.sv
// Per-frame monkey/wall/ladder overlap accumulator with a one-clock report
// issued the cycle after startOfFrame.
//
// state  | meaning
// ACCUM  | counting stage-1 hits; startOfFrame snapshots and clears counters
// REPORT | one cycle: report pulses high, counting of the new frame resumes
module monkey_collision_detector
  import monkey_pkg::*;
#(
  parameter int OBJECT_WIDTH  = OBJECT_WIDTH_DEF,
  parameter int OBJECT_HEIGHT = OBJECT_HEIGHT_DEF,
  parameter int EDGE_W        = EDGE_W_DEF,
  parameter int EDGE_H        = EDGE_H_DEF,
  parameter int HIT_THRESHOLD = HIT_THRESHOLD_DEF
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic [COORD_W-1:0] pixelX,
  input  logic [COORD_W-1:0] pixelY,
  input  logic [COORD_W-1:0] topLeftX,
  input  logic [COORD_W-1:0] topLeftY,
  input  logic               monkeyDR,
  input  logic               wallDR,
  input  logic               ladderDR,
  output logic               wallCollision,
  output logic               ladderCollision,
  output edge_code_t         HitEdgeCode
);

  localparam logic signed [OFF_W-1:0] W_S      = OFF_W'(OBJECT_WIDTH);
  localparam logic signed [OFF_W-1:0] H_S      = OFF_W'(OBJECT_HEIGHT);
  localparam logic signed [OFF_W-1:0] EW_S     = OFF_W'(EDGE_W);
  localparam logic signed [OFF_W-1:0] EH_S     = OFF_W'(EDGE_H);
  localparam logic signed [OFF_W-1:0] RIGHT_S  = OFF_W'(OBJECT_WIDTH - EDGE_W);
  localparam logic signed [OFF_W-1:0] BOTTOM_S = OFF_W'(OBJECT_HEIGHT - EDGE_H);
  localparam logic signed [OFF_W-1:0] ZERO_S   = '0;

  logic signed [OFF_W-1:0] off_x, off_y;
  logic                    in_sprite;
  logic                    wall_hit_d, lad_hit_d;
  edge_code_t              edge_hit_d;

  logic                    lad_hit_q;
  edge_code_t              edge_hit_q;

  fsm_t                    state_q, state_d;
  logic                    sof_accept;
  edge_code_t              edge_thr;
  logic                    lad_thr;

  logic                    wall_q, wall_d;
  logic                    lad_q, lad_d;
  edge_code_t              code_q, code_d;

  // Pixel is unsigned, top-left is two's complement; widen both by one bit.
  assign off_x = signed'({1'b0, pixelX}) - signed'({topLeftX[COORD_W-1], topLeftX});
  assign off_y = signed'({1'b0, pixelY}) - signed'({topLeftY[COORD_W-1], topLeftY});

  // Stage-1 classification of the current pixel against the sprite box.
  always_comb begin
    in_sprite  = (off_x >= ZERO_S) && (off_x < W_S) &&
                 (off_y >= ZERO_S) && (off_y < H_S);
    wall_hit_d = monkeyDR & wallDR & in_sprite;
    lad_hit_d  = monkeyDR & ladderDR & in_sprite;
    edge_hit_d = '0;
    edge_hit_d[EDGE_LEFT]   = wall_hit_d && (off_x < EW_S);
    edge_hit_d[EDGE_RIGHT]  = wall_hit_d && (off_x >= RIGHT_S);
    edge_hit_d[EDGE_TOP]    = wall_hit_d && (off_y < EH_S);
    edge_hit_d[EDGE_BOTTOM] = wall_hit_d && (off_y >= BOTTOM_S);
  end

  // Stage-1 pipeline register of per-band wall hits and the ladder hit.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      edge_hit_q <= '0;
      lad_hit_q  <= 1'b0;
    end else begin
      edge_hit_q <= edge_hit_d;
      lad_hit_q  <= lad_hit_d;
    end
  end

  // startOfFrame only matters in ACCUM; a stray one during REPORT is dropped.
  assign sof_accept = (state_q == ACCUM) && startOfFrame;

  for (genvar i = 0; i < 4; i++) begin : g_edge_cnt
    sat_hit_counter #(.THRESHOLD(HIT_THRESHOLD)) u_edge_cnt (
      .clk    (clk),
      .resetN (resetN),
      .clr_i  (sof_accept),
      .inc_i  (edge_hit_q[i] & ~sof_accept),
      .hit_o  (edge_thr[i])
    );
  end

  sat_hit_counter #(.THRESHOLD(HIT_THRESHOLD)) u_lad_cnt (
    .clk    (clk),
    .resetN (resetN),
    .clr_i  (sof_accept),
    .inc_i  (lad_hit_q & ~sof_accept),
    .hit_o  (lad_thr)
  );

  // Next state and report values; the snapshot is taken straight into the
  // output registers so the pulse is visible during the REPORT cycle itself.
  always_comb begin
    state_d = state_q;
    wall_d  = 1'b0;
    lad_d   = 1'b0;
    code_d  = code_q;
    case (state_q)
      ACCUM: begin
        if (startOfFrame) begin
          state_d = REPORT;
          code_d  = edge_thr;
          wall_d  = |edge_thr;
          lad_d   = lad_thr;
        end
      end
      REPORT: begin
        state_d = ACCUM;
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= ACCUM;
      wall_q  <= 1'b0;
      lad_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      wall_q  <= wall_d;
      lad_q   <= lad_d;
      code_q  <= code_d;
    end
  end

  assign wallCollision   = wall_q;
  assign ladderCollision = lad_q;
  assign HitEdgeCode     = code_q;

endmodule

// File: tb/tb_monkey_collision_detector.sv
// Directed bench for monkey_collision_detector.
module tb_monkey_collision_detector;

  logic        clk;
  logic        resetN;
  logic        startOfFrame;
  logic [10:0] pixelX, pixelY, topLeftX, topLeftY;
  logic        monkeyDR, wallDR, ladderDR;
  logic        wallCollision, ladderCollision;
  logic [3:0]  HitEdgeCode;

  int errors = 0;
  int checks = 0;

  monkey_collision_detector dut (
    .clk             (clk),
    .resetN          (resetN),
    .startOfFrame    (startOfFrame),
    .pixelX          (pixelX),
    .pixelY          (pixelY),
    .topLeftX        (topLeftX),
    .topLeftY        (topLeftY),
    .monkeyDR        (monkeyDR),
    .wallDR          (wallDR),
    .ladderDR        (ladderDR),
    .wallCollision   (wallCollision),
    .ladderCollision (ladderCollision),
    .HitEdgeCode     (HitEdgeCode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one pixel for one clock; returns 1 time unit after the edge.
  task automatic px(input int x, input int y, input logic m, input logic w, input logic l);
    pixelX   = 11'(x);
    pixelY   = 11'(y);
    monkeyDR = m;
    wallDR   = w;
    ladderDR = l;
    @(posedge clk);
    #1;
  endtask

  task automatic set_pos(input int x, input int y);
    topLeftX = 11'(x);
    topLeftY = 11'(y);
  endtask

  // Flush stage 1, pulse startOfFrame, check the report cycle and the one after.
  task automatic end_frame(input string name, input logic ew, input logic el, input logic [3:0] ec);
    px(0, 0, 1'b0, 1'b0, 1'b0);
    startOfFrame = 1'b1;
    checks++;
    if (wallCollision !== 1'b0 || ladderCollision !== 1'b0) begin
      errors++;
      $display("FAIL %s pulse on startOfFrame cycle: wall=%0b lad=%0b required 0 0", name, wallCollision, ladderCollision);
    end
    @(posedge clk);
    #1;
    startOfFrame = 1'b0;
    checks++;
    if (wallCollision !== ew || ladderCollision !== el || HitEdgeCode !== ec) begin
      errors++;
      $display("FAIL %s report: wall=%0b lad=%0b code=%b required wall=%0b lad=%0b code=%b",
               name, wallCollision, ladderCollision, HitEdgeCode, ew, el, ec);
    end
    @(posedge clk);
    #1;
    checks++;
    if (wallCollision !== 1'b0 || ladderCollision !== 1'b0 || HitEdgeCode !== ec) begin
      errors++;
      $display("FAIL %s after report: wall=%0b lad=%0b code=%b required wall=0 lad=0 code=%b",
               name, wallCollision, ladderCollision, HitEdgeCode, ec);
    end
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    startOfFrame = 1'b0;
    set_pos(280, 185);
    pixelX = '0; pixelY = '0; monkeyDR = 1'b0; wallDR = 1'b0; ladderDR = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (wallCollision !== 1'b0 || ladderCollision !== 1'b0 || HitEdgeCode !== 4'b0000) begin
      errors++;
      $display("FAIL reset_state: wall=%0b lad=%0b code=%b required 0 0 0000", wallCollision, ladderCollision, HitEdgeCode);
    end
    resetN = 1'b1;
    px(0, 0, 1'b0, 1'b0, 1'b0);
    end_frame("empty_first_frame", 1'b0, 1'b0, 4'b0000);
  endtask

  task automatic test_floor();
    for (int y = 241; y <= 242; y++)
      for (int x = 288; x <= 295; x++) px(x, y, 1'b1, 1'b1, 1'b0);
    end_frame("floor", 1'b1, 1'b0, 4'b0001);
  endtask

  task automatic test_left_wall();
    for (int y = 200; y <= 203; y++)
      for (int x = 280; x <= 283; x++) px(x, y, 1'b1, 1'b1, 1'b0);
    end_frame("left_wall", 1'b1, 1'b0, 4'b1000);
    end_frame("no_wall_after_left", 1'b0, 1'b0, 4'b0000);
  endtask

  task automatic test_threshold();
    px(280, 215, 1'b1, 1'b1, 1'b0);
    end_frame("single_pixel", 1'b0, 1'b0, 4'b0000);
    px(280, 215, 1'b1, 1'b1, 1'b0);
    px(280, 216, 1'b1, 1'b1, 1'b0);
    end_frame("two_pixels", 1'b1, 1'b0, 4'b1000);
  endtask

  task automatic test_boundaries();
    repeat (2) px(336, 215, 1'b1, 1'b1, 1'b0);
    end_frame("right_band_edge", 1'b1, 1'b0, 4'b0010);
    repeat (2) px(335, 215, 1'b1, 1'b1, 1'b0);
    end_frame("right_interior", 1'b0, 1'b0, 4'b0000);
    repeat (2) px(312, 192, 1'b1, 1'b1, 1'b0);
    end_frame("top_band_edge", 1'b1, 1'b0, 4'b0100);
    repeat (2) px(312, 193, 1'b1, 1'b1, 1'b0);
    end_frame("top_interior", 1'b0, 1'b0, 4'b0000);
    repeat (2) px(312, 241, 1'b1, 1'b1, 1'b0);
    end_frame("bottom_band_edge", 1'b1, 1'b0, 4'b0001);
    repeat (2) px(279, 215, 1'b1, 1'b1, 1'b0);
    repeat (2) px(344, 215, 1'b1, 1'b1, 1'b0);
    repeat (2) px(312, 184, 1'b1, 1'b1, 1'b0);
    repeat (2) px(312, 249, 1'b1, 1'b1, 1'b0);
    repeat (3) px(280, 215, 1'b0, 1'b1, 1'b0);
    end_frame("outside_or_transparent", 1'b0, 1'b0, 4'b0000);
  endtask

  task automatic test_ladder();
    repeat (3) px(312, 217, 1'b1, 1'b0, 1'b1);
    end_frame("ladder_center", 1'b0, 1'b1, 4'b0000);
    repeat (3) px(312, 217, 1'b0, 1'b0, 1'b1);
    end_frame("ladder_transparent", 1'b0, 1'b0, 4'b0000);
  endtask

  task automatic test_embedded();
    for (int y = 185; y < 249; y++)
      for (int x = 280; x < 344; x++) px(x, y, 1'b1, 1'b1, 1'b0);
    end_frame("embedded", 1'b1, 1'b0, 4'b1111);
  endtask

  task automatic test_negative();
    set_pos(-4, 100);
    for (int x = 0; x <= 3; x++) px(x, 120, 1'b1, 1'b1, 1'b0);
    end_frame("negative_x_left", 1'b1, 1'b0, 4'b1000);
    set_pos(-10, 100);
    for (int x = 0; x <= 5; x++) px(x, 120, 1'b1, 1'b1, 1'b0);
    end_frame("negative_x_interior", 1'b0, 1'b0, 4'b0000);
    set_pos(280, 185);
  endtask

  task automatic test_saturation();
    repeat (513) px(280, 215, 1'b1, 1'b1, 1'b0);
    end_frame("saturate_513", 1'b1, 1'b0, 4'b1000);
    px(280, 215, 1'b1, 1'b1, 1'b0);
    end_frame("cleared_after_saturation", 1'b0, 1'b0, 4'b0000);
  endtask

  task automatic test_reset_mid_frame();
    repeat (2) px(280, 215, 1'b1, 1'b1, 1'b0);
    end_frame("pre_reset_frame", 1'b1, 1'b0, 4'b1000);
    repeat (100) px(280, 215, 1'b1, 1'b1, 1'b0);
    #2;
    resetN = 1'b0;
    #1;
    checks++;
    if (wallCollision !== 1'b0 || ladderCollision !== 1'b0 || HitEdgeCode !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset: wall=%0b lad=%0b code=%b required 0 0 0000", wallCollision, ladderCollision, HitEdgeCode);
    end
    #2;
    resetN = 1'b1;
    px(280, 215, 1'b1, 1'b1, 1'b0);
    end_frame("post_reset_one_hit", 1'b0, 1'b0, 4'b0000);
    repeat (2) px(280, 215, 1'b1, 1'b1, 1'b0);
    end_frame("post_reset_two_hits", 1'b1, 1'b0, 4'b1000);
  endtask

  task automatic test_back_to_back();
    repeat (2) px(280, 215, 1'b1, 1'b1, 1'b0);
    px(0, 0, 1'b0, 1'b0, 1'b0);
    startOfFrame = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (wallCollision !== 1'b1 || HitEdgeCode !== 4'b1000) begin
      errors++;
      $display("FAIL sof_in_report first: wall=%0b code=%b required 1 1000", wallCollision, HitEdgeCode);
    end
    @(posedge clk);
    #1;
    startOfFrame = 1'b0;
    checks++;
    if (wallCollision !== 1'b0 || HitEdgeCode !== 4'b1000) begin
      errors++;
      $display("FAIL sof_in_report ignored: wall=%0b code=%b required 0 1000", wallCollision, HitEdgeCode);
    end
    repeat (2) px(312, 241, 1'b1, 1'b1, 1'b0);
    end_frame("after_ignored_sof", 1'b1, 1'b0, 4'b0001);
  endtask

  initial begin
    test_reset();
    test_floor();
    test_left_wall();
    test_threshold();
    test_boundaries();
    test_ladder();
    test_embedded();
    test_negative();
    test_saturation();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
